// File: rtl/radix4_stage_stream.sv
// Streaming first radix-4 stage of an N-point FFT.
// Loads one complex frame over a valid/ready handshake, runs N/4 in-place
// radix-4 butterflies (stride N/4), then unloads results in index order.
// Supports forward/inverse twiddle (W = -j / +j), divide-by-4 scaling or
// saturation to DW bits, a per-sample saturation flag and a sticky framing error.
module radix4_stage_stream #(
   parameter int DW    = 16,
   parameter int LOG2N = 4,
   parameter int SCALE = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   input  logic          in_last,
   input  logic          inv,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic          out_last,
   output logic          out_sat,
   output logic          frame_err
);

   localparam int N  = 1 << LOG2N;
   localparam int Q  = N / 4;                        // butterfly stride / group count
   localparam int GW = (LOG2N > 2) ? LOG2N - 2 : 1;  // group counter width
   localparam int EW = DW + 2;                       // full-precision butterfly width

   localparam logic [1:0] S_LOAD    = 2'd0;
   localparam logic [1:0] S_COMPUTE = 2'd1;
   localparam logic [1:0] S_UNLOAD  = 2'd2;

   localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};
   localparam logic [GW-1:0]    LAST_GRP = GW'(Q - 1);

   localparam logic signed [EW-1:0] MAX_V = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [EW-1:0] MIN_V = {3'b111, {(DW-1){1'b0}}};

   logic [1:0]       state;
   logic [LOG2N-1:0] idx;      // load write index, later unload read index
   logic [GW-1:0]    grp;      // butterfly group being computed
   logic             inv_q;    // direction latched with the last input sample
   logic             load_hs;

   logic [DW-1:0]    buf_re [N];
   logic [DW-1:0]    buf_im [N];
   logic [N-1:0]     sat_q;

   logic [LOG2N-1:0]       addr   [4];
   logic signed [EW-1:0]   op_re  [4];
   logic signed [EW-1:0]   op_im  [4];
   logic signed [EW-1:0]   f_re   [4];
   logic signed [EW-1:0]   f_im   [4];
   logic [DW:0]            fit_re [4];
   logic [DW:0]            fit_im [4];

   // Scale (>>>2, truncated) or saturate one full-precision value; MSB = clamped.
   function automatic logic [DW:0] fit(input logic signed [EW-1:0] v);
      logic [DW-1:0] sc;
      logic [DW:0]   r;
      sc = DW'(v >>> 2);
      if (SCALE != 0)     r = {1'b0, sc};
      else if (v > MAX_V) r = {1'b1, MAX_V[DW-1:0]};
      else if (v < MIN_V) r = {1'b1, MIN_V[DW-1:0]};
      else                r = {1'b0, v[DW-1:0]};
      return r;
   endfunction

   assign in_ready = rst_n & (state == S_LOAD);
   assign load_hs  = in_valid & in_ready;

   // Gather the four butterfly operands x[g + k*N/4], sign-extended to EW bits.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
      for (int k = 0; k < 4; k++) begin
         addr[k]  = {{(LOG2N-GW){1'b0}}, grp} + LOG2N'(k * Q);
         op_re[k] = {{2{buf_re[addr[k]][DW-1]}}, buf_re[addr[k]]};
         op_im[k] = {{2{buf_im[addr[k]][DW-1]}}, buf_im[addr[k]]};
      end
   end

   // Radix-4 butterfly; inverse mode swaps the X1 and X3 expressions.
   always_comb begin
      f_re[0] = op_re[0] + op_re[1] + op_re[2] + op_re[3];
      f_im[0] = op_im[0] + op_im[1] + op_im[2] + op_im[3];
      f_re[2] = op_re[0] - op_re[1] + op_re[2] - op_re[3];
      f_im[2] = op_im[0] - op_im[1] + op_im[2] - op_im[3];
      f_re[1] = op_re[0] + op_im[1] - op_re[2] - op_im[3];
      f_im[1] = op_im[0] - op_re[1] - op_im[2] + op_re[3];
      f_re[3] = op_re[0] - op_im[1] - op_re[2] + op_im[3];
      f_im[3] = op_im[0] + op_re[1] - op_im[2] - op_re[3];
      if (inv_q) begin
         f_re[1] = op_re[0] - op_im[1] - op_re[2] + op_im[3];
         f_im[1] = op_im[0] + op_re[1] - op_im[2] - op_re[3];
         f_re[3] = op_re[0] + op_im[1] - op_re[2] - op_im[3];
         f_im[3] = op_im[0] - op_re[1] - op_im[2] + op_re[3];
      end
   end

   // Reduce each butterfly output to DW bits.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         fit_re[k] = fit(f_re[k]);
         fit_im[k] = fit(f_im[k]);
      end
   end

   // Frame buffer: written by the load handshake, then in place by each butterfly group.
   // NOTE: the buffer has no reset; every entry is written before it is read.
   always_ff @(posedge clk) begin
      if (load_hs) begin
         buf_re[idx] <= in_re;
         buf_im[idx] <= in_im;
      end else if (state == S_COMPUTE) begin
         for (int k = 0; k < 4; k++) begin
            buf_re[addr[k]] <= fit_re[k][DW-1:0];
            buf_im[addr[k]] <= fit_im[k][DW-1:0];
            sat_q[addr[k]]  <= fit_re[k][DW] | fit_im[k][DW];
         end
      end
   end

   // Control FSM, framing check and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst_n) begin
         state     <= S_LOAD;
         idx       <= '0;
         grp       <= '0;
         inv_q     <= 1'b0;
         frame_err <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_last  <= 1'b0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               if (load_hs) begin
                  if (in_last != (idx == LAST_IDX)) frame_err <= 1'b1;
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     grp   <= '0;
                     inv_q <= inv;
                     state <= S_COMPUTE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               if (grp == LAST_GRP) begin
                  grp   <= '0;
                  state <= S_UNLOAD;
               end else begin
                  grp <= grp + 1'b1;
               end
            end
            S_UNLOAD: begin
               if (!out_valid || out_ready) begin
                  if (out_valid && out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     idx       <= '0;
                     state     <= S_LOAD;
                  end else begin
                     out_valid <= 1'b1;
                     out_re    <= buf_re[idx];
                     out_im    <= buf_im[idx];
                     out_sat   <= sat_q[idx];
                     out_last  <= (idx == LAST_IDX);
                     idx       <= idx + 1'b1;
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_radix4_stage_stream.sv
// Directed bench for radix4_stage_stream (N=16). Two instances share stimulus:
// dut0 saturates (SCALE=0), dut1 scales by 4 (SCALE=1).
module tb_radix4_stage_stream;

   localparam int DW    = 16;
   localparam int LOG2N = 4;
   localparam int N     = 16;
   localparam int Q     = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_re = '0;
   logic [DW-1:0] in_im = '0;
   logic          in_last = 1'b0;
   logic          inv = 1'b0;
   logic          out_ready = 1'b0;

   logic          in_ready0, o0_valid, o0_last, o0_sat, frame_err0;
   logic [DW-1:0] o0_re, o0_im;
   logic          in_ready1, o1_valid, o1_last, o1_sat, frame_err1;
   logic [DW-1:0] o1_re, o1_im;

   radix4_stage_stream #(.DW(DW), .LOG2N(LOG2N), .SCALE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_re(in_re), .in_im(in_im), .in_last(in_last), .inv(inv),
      .out_valid(o0_valid), .out_ready(out_ready), .out_re(o0_re), .out_im(o0_im),
      .out_last(o0_last), .out_sat(o0_sat), .frame_err(frame_err0)
   );

   radix4_stage_stream #(.DW(DW), .LOG2N(LOG2N), .SCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_re(in_re), .in_im(in_im), .in_last(in_last), .inv(inv),
      .out_valid(o1_valid), .out_ready(out_ready), .out_re(o1_re), .out_im(o1_im),
      .out_last(o1_last), .out_sat(o1_sat), .frame_err(frame_err1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic signed [DW-1:0] x_re [N];
   logic signed [DW-1:0] x_im [N];
   logic [DW-1:0] e0_re [N];
   logic [DW-1:0] e0_im [N];
   logic          e0_sat [N];
   logic [DW-1:0] e1_re [N];
   logic [DW-1:0] e1_im [N];
   logic          e1_sat [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Golden model: X_k = sum_m x[g+m*N/4] * W^(m*k), W = -j forward, +j inverse.
   function automatic void model(input bit inv_m);
      for (int g = 0; g < Q; g++) begin
         for (int k = 0; k < 4; k++) begin
            int sr = 0;
            int si = 0;
            int o  = g + k * Q;
            int c0, c1;
            bit s0;
            for (int m = 0; m < 4; m++) begin
               int r = x_re[g + m * Q];
               int i = x_im[g + m * Q];
               int t = (m * k) % 4;
               if (inv_m) t = (4 - t) % 4;
               case (t)
                  0: begin sr += r;  si += i;  end
                  1: begin sr += i;  si -= r;  end
                  2: begin sr -= r;  si -= i;  end
                  default: begin sr -= i; si += r; end
               endcase
            end
            s0 = 0;
            c0 = sr; c1 = si;
            if (c0 > 32767)  begin c0 = 32767;  s0 = 1; end
            if (c0 < -32768) begin c0 = -32768; s0 = 1; end
            if (c1 > 32767)  begin c1 = 32767;  s0 = 1; end
            if (c1 < -32768) begin c1 = -32768; s0 = 1; end
            e0_re[o] = 16'(c0); e0_im[o] = 16'(c1); e0_sat[o] = s0;
            e1_re[o] = 16'(sr >>> 2); e1_im[o] = 16'(si >>> 2); e1_sat[o] = 1'b0;
         end
      end
   endfunction

   function automatic void clear_x();
      for (int i = 0; i < N; i++) begin x_re[i] = '0; x_im[i] = '0; end
   endfunction

   function automatic void random_x();
      for (int i = 0; i < N; i++) begin
         x_re[i] = 16'($urandom);
         x_im[i] = 16'($urandom);
      end
   endfunction

   // Drive one frame; inv carries the wrong value except on the last sample.
   task automatic send_frame(input bit inv_i, input int last_at, input bit gaps, output int e_edge);
      for (int i = 0; i < N; i++) begin
         bit done = 0;
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_re    = x_re[i];
         in_im    = x_im[i];
         in_last  = (i == last_at);
         inv      = (i == N - 1) ? inv_i : ~inv_i;
         for (int w = 0; w < 50 && !done; w++) begin
            @(negedge clk);
            if (in_ready0) done = 1;
            @(posedge clk); #1;
         end
         if (!done) check("in_ready_timeout", 0, 1);
      end
      e_edge   = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Collect stop_at outputs from both instances and compare against e0_*/e1_*.
   task automatic recv_frame(input bit stall, input int stop_at, output int first_edge);
      int i = 0;
      int budget = 0;
      bit held = 0;
      logic [DW-1:0] hr = '0;
      logic [DW-1:0] hi = '0;
      first_edge = -1;
      while (i < stop_at && budget < 1000) begin
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         budget++;
         check("in_ready_busy", {in_ready1, in_ready0}, 0);
         if (o0_valid) begin
            if (first_edge < 0) first_edge = cyc;
            check($sformatf("valid1_y%0d", i), o1_valid, 1);
            if (held) begin
               check($sformatf("hold_re_y%0d", i), o0_re, hr);
               check($sformatf("hold_im_y%0d", i), o0_im, hi);
            end
            if (out_ready) begin
               check($sformatf("s0_re_y%0d", i), o0_re, e0_re[i]);
               check($sformatf("s0_im_y%0d", i), o0_im, e0_im[i]);
               check($sformatf("s0_sat_y%0d", i), o0_sat, e0_sat[i]);
               check($sformatf("s0_last_y%0d", i), o0_last, (i == N - 1));
               check($sformatf("s1_re_y%0d", i), o1_re, e1_re[i]);
               check($sformatf("s1_im_y%0d", i), o1_im, e1_im[i]);
               check($sformatf("s1_sat_y%0d", i), o1_sat, e1_sat[i]);
               check($sformatf("s1_last_y%0d", i), o1_last, (i == N - 1));
               i++;
               held = 0;
            end else begin
               held = 1;
               hr = o0_re;
               hi = o0_im;
            end
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      if (budget >= 1000) check("recv_timeout", 0, 1);
   endtask

   // After a complete unload the block must idle with in_ready high.
   task automatic check_idle(input string tag);
      @(negedge clk);
      check({tag, "_valid"}, {o1_valid, o0_valid}, 0);
      check({tag, "_ready"}, {in_ready1, in_ready0}, 2'b11);
      @(posedge clk); #1;
   endtask

   initial begin
      int e_edge, f_edge;

      // Reset state.
      #1;
      check("rst_in_ready", in_ready0, 0);
      check("rst_out_valid", o0_valid, 0);
      check("rst_out_re", o0_re, 0);
      check("rst_out_im", o0_im, 0);
      check("rst_out_last", o0_last, 0);
      check("rst_out_sat", o0_sat, 0);
      check("rst_frame_err", frame_err0, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Impulse at x[0]: ones at y[0], y[4], y[8], y[12]; latency check.
      clear_x();
      x_re[0] = 16'sd1;
      model(1'b0);
      for (int i = 0; i < N; i++) begin
         e0_re[i] = (i % 4 == 0) ? 16'd1 : 16'd0;
         e0_im[i] = 16'd0;
         e0_sat[i] = 1'b0;
      end
      send_frame(1'b0, N - 1, 1'b0, e_edge);
      recv_frame(1'b0, N, f_edge);
      check("latency", f_edge - e_edge, 5);
      check_idle("impulse_idle");

      // Group 0 forward: y0=5, y4=1-2j, y8=-3, y12=1+2j.
      clear_x();
      x_re[0] = 16'sd1; x_re[4] = 16'sd3; x_re[12] = 16'sd1;
      model(1'b0);
      for (int i = 0; i < N; i++) begin e0_re[i] = '0; e0_im[i] = '0; e0_sat[i] = 1'b0; end
      e0_re[0]  = 16'd5;
      e0_re[4]  = 16'd1;      e0_im[4]  = 16'hFFFE;
      e0_re[8]  = 16'hFFFD;
      e0_re[12] = 16'd1;      e0_im[12] = 16'd2;
      send_frame(1'b0, N - 1, 1'b0, e_edge);
      recv_frame(1'b0, N, f_edge);
      check_idle("grp_fwd_idle");

      // Same group inverse: y4=1+2j, y12=1-2j.
      model(1'b1);
      e0_im[4] = 16'd2; e0_im[12] = 16'hFFFE;
      send_frame(1'b1, N - 1, 1'b0, e_edge);
      recv_frame(1'b0, N, f_edge);
      check_idle("grp_inv_idle");

      // Saturation vs scaling: 4 x 0x7FFF into group 0.
      clear_x();
      x_re[0] = 16'sh7FFF; x_re[4] = 16'sh7FFF; x_re[8] = 16'sh7FFF; x_re[12] = 16'sh7FFF;
      for (int i = 0; i < N; i++) begin
         e0_re[i] = '0; e0_im[i] = '0; e0_sat[i] = 1'b0;
         e1_re[i] = '0; e1_im[i] = '0; e1_sat[i] = 1'b0;
      end
      e0_re[0] = 16'h7FFF; e0_sat[0] = 1'b1;
      e1_re[0] = 16'h7FFF;
      send_frame(1'b0, N - 1, 1'b0, e_edge);
      recv_frame(1'b0, N, f_edge);
      check_idle("sat_idle");
      check("no_frame_err", frame_err0, 0);

      // Random frames with input gaps and output stalls.
      for (int f = 0; f < 2; f++) begin
         bit di = f[0];
         random_x();
         model(di);
         send_frame(di, N - 1, 1'b1, e_edge);
         recv_frame(1'b1, N, f_edge);
         check_idle("rand_idle");
      end

      // Early in_last on sample 7: error is sticky, frame still 16 samples.
      random_x();
      model(1'b0);
      send_frame(1'b0, 7, 1'b0, e_edge);
      check("frame_err_set", {frame_err1, frame_err0}, 2'b11);
      recv_frame(1'b1, N, f_edge);
      check_idle("err_idle");
      random_x();
      model(1'b1);
      send_frame(1'b1, N - 1, 1'b1, e_edge);
      recv_frame(1'b0, N, f_edge);
      check("frame_err_sticky", frame_err0, 1);

      // Reset while presenting y[6]; next frame must be clean.
      random_x();
      model(1'b0);
      send_frame(1'b0, N - 1, 1'b0, e_edge);
      recv_frame(1'b0, 6, f_edge);
      @(negedge clk);
      check("pre_rst_valid", o0_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", o0_valid, 0);
      check("mid_rst_ready", in_ready0, 0);
      check("mid_rst_frame_err", frame_err0, 0);
      check("mid_rst_re", o0_re, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      random_x();
      model(1'b1);
      send_frame(1'b1, N - 1, 1'b1, e_edge);
      recv_frame(1'b1, N, f_edge);
      check_idle("post_rst_idle");
      check("post_rst_frame_err", frame_err0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
